// File: rtl/i2c_slave_responder.sv
// I2C target answering one fixed 7-bit address. SCL/SDA are oversampled on clk_i.
// Written bytes are strobed out; read bytes are requested from local logic while SCL is stretched.
module i2c_slave_responder #(
  parameter int                      I2C_ADDR_WIDTH = 7,
  parameter int                      I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR   = 7'h22,
  parameter int                      SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      wr_valid_o,
  output logic                      rd_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  input  logic                      rd_valid_i,
  output logic                      busy_o,
  output logic                      op_o,
  output logic                      stop_o
);
  localparam int SW = (I2C_ADDR_WIDTH + 1 > I2C_DATA_WIDTH) ? I2C_ADDR_WIDTH + 1 : I2C_DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] ADDR_BITS = CW'(I2C_ADDR_WIDTH + 1);
  localparam logic [CW-1:0] DATA_BITS = CW'(I2C_DATA_WIDTH);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] WR_DATA  = 4'd3;
  localparam logic [3:0] WR_ACK   = 4'd4;
  localparam logic [3:0] RD_WAIT  = 4'd5;
  localparam logic [3:0] RD_DATA  = 4'd6;
  localparam logic [3:0] RD_ACK   = 4'd7;
  localparam logic [3:0] IGNORE   = 4'd8;

  logic [SYNC_STAGES-1:0]    r_scl_sync, r_sda_sync;
  logic                      r_scl_d, r_sda_d;
  logic [3:0]                r_state;
  logic [CW-1:0]             r_bit_cnt;
  logic [SW-1:0]             r_shift;
  logic [I2C_DATA_WIDTH-1:0] r_rd_byte;
  logic [I2C_DATA_WIDTH-1:0] r_wr_data;
  logic                      r_scl_o, r_sda_o, r_wr_valid, r_rd_req;
  logic                      r_busy, r_op, r_stop, r_ack_bit;

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_match;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high on both samples so an SCL edge coinciding with an SDA change is not a condition
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_match    = (r_shift[I2C_ADDR_WIDTH:1] == SLAVE_ADDR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rd_byte  <= '0;
      r_wr_data  <= '0;
      r_scl_o    <= 1'b1;
      r_sda_o    <= 1'b1;
      r_wr_valid <= 1'b0;
      r_rd_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_op       <= 1'b0;
      r_stop     <= 1'b0;
      r_ack_bit  <= 1'b1;
    end else begin
      r_wr_valid <= 1'b0;
      r_rd_req   <= 1'b0;
      r_stop     <= 1'b0;
      if (w_stop) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_scl_o   <= 1'b1;
        r_sda_o   <= 1'b1;
        r_busy    <= 1'b0;
        r_stop    <= r_busy;
      end else if (w_start) begin
        r_state   <= ADDR;
        r_bit_cnt <= '0;
        r_scl_o   <= 1'b1;
        r_sda_o   <= 1'b1;
      end else begin
        case (r_state)
          ADDR: begin
            if (w_scl_rise && r_bit_cnt != ADDR_BITS) begin
              r_shift   <= {r_shift[SW-2:0], w_sda};
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end else if (w_scl_fall && r_bit_cnt == ADDR_BITS) begin
              if (w_match) begin
                r_sda_o <= 1'b0;
                r_busy  <= 1'b1;
                r_op    <= r_shift[0];
                r_state <= ADDR_ACK;
              end else begin
                r_state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (w_scl_fall) begin
              r_sda_o   <= 1'b1;
              r_bit_cnt <= '0;
              if (r_op) begin
                r_rd_req <= 1'b1;
                r_scl_o  <= 1'b0;
                r_state  <= RD_WAIT;
              end else begin
                r_state  <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (w_scl_rise && r_bit_cnt != DATA_BITS) begin
              r_shift   <= {r_shift[SW-2:0], w_sda};
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end else if (w_scl_fall && r_bit_cnt == DATA_BITS) begin
              r_wr_data  <= r_shift[I2C_DATA_WIDTH-1:0];
              r_wr_valid <= 1'b1;
              r_sda_o    <= 1'b0;
              r_state    <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_o   <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= WR_DATA;
            end
          end
          RD_WAIT: begin
            if (rd_valid_i) begin
              r_sda_o   <= rd_data_i[I2C_DATA_WIDTH-1];
              r_rd_byte <= {rd_data_i[I2C_DATA_WIDTH-2:0], 1'b0};
              r_bit_cnt <= CW'(1);
              r_state   <= RD_DATA;
            end
          end
          RD_DATA: begin
            // SCL is let go one cycle after the MSB is on SDA, giving setup before the master's rise
            if (!r_scl_o) begin
              r_scl_o <= 1'b1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == DATA_BITS) begin
                r_sda_o <= 1'b1;
                r_state <= RD_ACK;
              end else begin
                r_sda_o   <= r_rd_byte[I2C_DATA_WIDTH-1];
                r_rd_byte <= {r_rd_byte[I2C_DATA_WIDTH-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + CW'(1);
              end
            end
          end
          RD_ACK: begin
            if (w_scl_rise) begin
              r_ack_bit <= w_sda;
            end else if (w_scl_fall) begin
              if (!r_ack_bit) begin
                r_rd_req <= 1'b1;
                r_scl_o  <= 1'b0;
                r_state  <= RD_WAIT;
              end else begin
                r_state  <= IGNORE;
              end
            end
          end
          default: begin
            r_scl_o <= 1'b1;
            r_sda_o <= 1'b1;
          end
        endcase
      end
    end
  end

  assign scl_o      = r_scl_o;
  assign sda_o      = r_sda_o;
  assign wr_data_o  = r_wr_data;
  assign wr_valid_o = r_wr_valid;
  assign rd_req_o   = r_rd_req;
  assign busy_o     = r_busy;
  assign op_o       = r_op;
  assign stop_o     = r_stop;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: behavioural I2C master on a wired-AND bus plus a local read-data responder.
module tb_i2c_slave_responder;
  localparam int QP = 8;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       m_scl, m_sda;
  logic       scl_i, sda_i, scl_o, sda_o;
  logic [7:0] wr_data_o, rd_data_i;
  logic       wr_valid_o, rd_req_o, rd_valid_i, busy_o, op_o, stop_o;

  assign scl_i = m_scl & scl_o;
  assign sda_i = m_sda & sda_o;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .clk_i(clk), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
    .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o), .rd_req_o(rd_req_o), .rd_data_i(rd_data_i),
    .rd_valid_i(rd_valid_i), .busy_o(busy_o), .op_o(op_o), .stop_o(stop_o)
  );

  int total = 0, bad = 0;
  int tmo_bound = 2000;
  int wr_cnt = 0, rd_cnt = 0, stop_cnt = 0, both_cnt = 0, low_run = 0;
  int rd_delay = 0;
  logic [7:0] wr_q[$];
  logic [7:0] rd_q[$];
  int stretch_q[$];

  always @(negedge clk) begin
    if (wr_valid_o) begin wr_cnt++; wr_q.push_back(wr_data_o); end
    if (rd_req_o) rd_cnt++;
    if (stop_o) stop_cnt++;
    if (wr_valid_o && rd_req_o) both_cnt++;
    if (!scl_o) low_run++;
    else if (low_run > 0) begin stretch_q.push_back(low_run); low_run = 0; end
  end

  // local logic: answers each rd_req_o after rd_delay cycles (0 = same cycle as the request)
  initial begin
    rd_valid_i = 1'b0;
    rd_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_req_o) begin
        repeat (rd_delay) @(negedge clk);
        rd_data_i  = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
        rd_valid_i = 1'b1;
        @(negedge clk);
        rd_valid_i = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, want done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (scl_i !== 1'b1 && n < tmo_bound) begin wait_clks(1); n++; end
    if (n >= tmo_bound) begin
      total++; bad++; tmo_bound = 20;
      $display("FAIL scl_release: scl_i still low after %0d clk, want high", n);
    end
  endtask

  // every bus routine starts and ends just after an SCL fall (except start from idle)
  task automatic i2c_bit(input logic b, output logic r);
    wait_clks(QP); m_sda = b;
    wait_clks(QP); m_scl = 1'b1;
    wait_scl_high();
    wait_clks(QP); r = sda_i;
    wait_clks(QP); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clks(QP); m_sda = 1'b1;
    wait_clks(QP); m_scl = 1'b1;
    wait_scl_high();
    wait_clks(2*QP); m_sda = 1'b0;
    wait_clks(2*QP); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(QP); m_sda = 1'b0;
    wait_clks(QP); m_scl = 1'b1;
    wait_scl_high();
    wait_clks(2*QP); m_sda = 1'b1;
    wait_clks(2*QP);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin i2c_bit(1'b1, r); d[i] = r; end
    i2c_bit(~mack, r);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_ack;   // target answers address and data
  } wvec_t;

  initial begin
    wvec_t      vt[6];
    logic       a, d;
    logic [7:0] rb;
    logic [7:0] exp_wd = 8'h00;
    int         w0, r0, s0, nacks;

    vt[0] = '{7'h22, 8'h78, 1'b1};
    vt[1] = '{7'h23, 8'h55, 1'b0};
    vt[2] = '{7'h00, 8'h11, 1'b0};
    vt[3] = '{7'h22, 8'hFF, 1'b1};
    vt[4] = '{7'h62, 8'hAA, 1'b0};
    vt[5] = '{7'h22, 8'h00, 1'b1};

    m_scl = 1'b1; m_sda = 1'b1; rst_i = 1'b0;
    wait_clks(5);
    chk("rst_scl_o", 32'(scl_o), 1);
    chk("rst_sda_o", 32'(sda_o), 1);
    chk("rst_wr_data", 32'(wr_data_o), 0);
    chk("rst_wr_valid", 32'(wr_valid_o), 0);
    chk("rst_rd_req", 32'(rd_req_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_op", 32'(op_o), 0);
    chk("rst_stop", 32'(stop_o), 0);
    rst_i = 1'b1;
    wait_clks(5);

    // single-byte writes to matching and non-matching addresses
    for (int i = 0; i < 6; i++) begin
      w0 = wr_cnt; r0 = rd_cnt; s0 = stop_cnt;
      i2c_start();
      wr_byte({vt[i].addr, 1'b0}, a);
      chk($sformatf("v%0d_addr_ack", i), 32'(a), 32'(vt[i].exp_ack));
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vt[i].exp_ack));
      if (vt[i].exp_ack) chk($sformatf("v%0d_op", i), 32'(op_o), 0);
      wr_byte(vt[i].data, d);
      chk($sformatf("v%0d_data_ack", i), 32'(d), 32'(vt[i].exp_ack));
      i2c_stop();
      if (vt[i].exp_ack) exp_wd = vt[i].data;
      chk($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt - w0), 32'(vt[i].exp_ack));
      chk($sformatf("v%0d_wr_data", i), 32'(wr_data_o), 32'(exp_wd));
      chk($sformatf("v%0d_rd_req", i), 32'(rd_cnt - r0), 0);
      chk($sformatf("v%0d_stop", i), 32'(stop_cnt - s0), 32'(vt[i].exp_ack));
      chk($sformatf("v%0d_busy_end", i), 32'(busy_o), 0);
    end

    // 32-byte burst write
    wr_q.delete();
    nacks = 0;
    i2c_start();
    wr_byte(8'h44, a);
    chk("burst_addr_ack", 32'(a), 1);
    for (int i = 0; i < 32; i++) begin
      wr_byte(8'(i), d);
      if (!d) nacks++;
    end
    i2c_stop();
    chk("burst_nacks", 32'(nacks), 0);
    chk("burst_count", 32'(wr_q.size()), 32);
    for (int i = 0; i < 32 && i < wr_q.size(); i++)
      chk($sformatf("burst_byte%0d", i), 32'(wr_q[i]), 32'(i));

    // two-byte read with slow local logic
    rd_q.push_back(8'h64); rd_q.push_back(8'h65);
    rd_delay = 50;
    stretch_q.delete();
    r0 = rd_cnt; s0 = stop_cnt;
    i2c_start();
    wr_byte(8'h45, a);
    chk("rd_addr_ack", 32'(a), 1);
    chk("rd_op", 32'(op_o), 1);
    chk("rd_busy", 32'(busy_o), 1);
    rd_byte(1'b1, rb);
    chk("rd_byte0", 32'(rb), 32'h64);
    rd_byte(1'b0, rb);
    chk("rd_byte1", 32'(rb), 32'h65);
    chk("rd_busy_after_nack", 32'(busy_o), 1);
    i2c_stop();
    chk("rd_req_count", 32'(rd_cnt - r0), 2);
    chk("rd_stretch_runs", 32'(stretch_q.size()), 2);
    for (int i = 0; i < stretch_q.size(); i++)
      chk($sformatf("rd_stretch%0d_ge50", i), 32'(stretch_q[i] >= 50), 1);
    chk("rd_stop", 32'(stop_cnt - s0), 1);
    chk("rd_busy_end", 32'(busy_o), 0);

    // write then repeated START read; local logic answers in the request cycle
    rd_delay = 0;
    rd_q.push_back(8'hA5);
    w0 = wr_cnt; r0 = rd_cnt; s0 = stop_cnt;
    i2c_start();
    wr_byte(8'h44, a);
    chk("wr_rd_addr_ack", 32'(a), 1);
    chk("wr_rd_op_w", 32'(op_o), 0);
    wr_byte(8'h05, d);
    chk("wr_rd_data_ack", 32'(d), 1);
    chk("wr_rd_wr_data", 32'(wr_data_o), 32'h05);
    i2c_start();
    wr_byte(8'h45, a);
    chk("wr_rd_raddr_ack", 32'(a), 1);
    chk("wr_rd_op_r", 32'(op_o), 1);
    rd_byte(1'b0, rb);
    chk("wr_rd_rbyte", 32'(rb), 32'hA5);
    i2c_stop();
    chk("wr_rd_wr_cnt", 32'(wr_cnt - w0), 1);
    chk("wr_rd_rd_cnt", 32'(rd_cnt - r0), 1);
    chk("wr_rd_stop", 32'(stop_cnt - s0), 1);
    chk("wr_rd_busy_end", 32'(busy_o), 0);

    // reset while SCL is being stretched
    rd_delay = 100;
    i2c_start();
    wr_byte(8'h45, a);
    chk("rs_addr_ack", 32'(a), 1);
    wait_clks(10);
    chk("rs_pre_scl", 32'(scl_o), 0);
    rst_i = 1'b0;
    #1;
    chk("rs_scl_rel", 32'(scl_o), 1);
    chk("rs_sda_rel", 32'(sda_o), 1);
    chk("rs_busy", 32'(busy_o), 0);
    wait_clks(2);
    i2c_stop();
    rst_i = 1'b1;
    wait_clks(150);
    rd_delay = 0;

    // reset mid read data byte while target and master both pull SDA low
    rd_q.push_back(8'h00);
    i2c_start();
    wr_byte(8'h45, a);
    chk("rd_rst_addr_ack", 32'(a), 1);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1, d);
    m_sda = 1'b0;
    wait_clks(6);
    chk("rd_rst_pre_sda", 32'(sda_o), 0);
    rst_i = 1'b0;
    #1;
    chk("rd_rst_sda_rel", 32'(sda_o), 1);
    chk("rd_rst_scl_rel", 32'(scl_o), 1);
    wait_clks(2);
    i2c_stop();
    rst_i = 1'b1;
    wait_clks(10);
    i2c_start();
    wr_byte(8'h44, a);
    chk("post_rst_addr_ack", 32'(a), 1);
    wr_byte(8'h3C, d);
    chk("post_rst_data_ack", 32'(d), 1);
    i2c_stop();
    chk("post_rst_wr_data", 32'(wr_data_o), 32'h3C);
    chk("post_rst_busy", 32'(busy_o), 0);

    chk("no_wr_rd_overlap", 32'(both_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
